// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and helpers for the 4x4 keypad scanner.
//   - state_e      : press/release state machine states
//   - scan_res_e   : classification of one complete 16-position scan
//   - NO_KEY       : active-low one-hot code shown when no key is held
//   - idx_to_onehot_low : 2-bit index -> active-low one-hot nibble
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } scan_res_e;

    localparam logic [3:0] NO_KEY = 4'hF;

    function automatic logic [3:0] idx_to_onehot_low(input logic [1:0] idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Key report bundle from the scanner to the vending-machine controller.
//   - c, r      : held key column/row, active-low one-hot (4'hF = none)
//   - key_code  : {col[1:0], row[1:0]} of the last accepted key
//   - key_valid : one-clock pulse when a press is accepted
//   - key_down  : high while the accepted key is held
//   modport master : scanner side (drives everything)
//   modport slave  : controller side (reads everything)
interface keypad_scanner_if;

    logic [3:0] c;
    logic [3:0] r;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        output c,
        output r,
        output key_code,
        output key_valid,
        output key_down
    );

    modport slave (
        input c,
        input r,
        input key_code,
        input key_valid,
        input key_down
    );

endinterface

// File: rtl/keypad_scanner_row_sync.sv
// row_sync
//   Two-flop synchronizer for the four keypad row lines, which are
//   asynchronous to clk. Resets to "all rows high" (no key).
//   Ports:
//     clk   in  : system clock
//     reset in  : asynchronous active-low reset
//     d     in  : raw rows (active-low)
//     q     out : synchronized rows (active-low), 2 clocks latency
module row_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= NO_KEY;
            sync2_q <= NO_KEY;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 membrane keypad one column at a time, classifies each full
//   scan as NONE / SINGLE / MULTI and debounces presses and releases over
//   DEBOUNCE_CNT consecutive scans.
//   Parameters:
//     SCAN_DIV     : clocks each column is driven (>= 4)
//     DEBOUNCE_CNT : consecutive scans needed to accept a press or release (>= 1)
//   Ports:
//     clk     in  : system clock
//     reset   in  : asynchronous active-low reset
//     col_drv out : column drive, active-low one-hot
//     row_in  in  : keypad rows, active-low, asynchronous
//     kp      if  : key report (c, r, key_code, key_valid, key_down)
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [3:0]        col_drv,
    input  logic [3:0]        row_in,
    keypad_scanner_if.master  kp
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CNT);

    function automatic logic [2:0] pop4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Counter never wraps: it holds once it reaches DEBOUNCE_CNT.
    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [3:0]    row_s;

    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    acc_n_q, acc_n_d;     // low bits seen so far this scan, saturating at 2
    logic [3:0]    acc_key_q, acc_key_d; // position of the first low bit seen
    state_e        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    c_q, c_d;
    logic [3:0]    r_q, r_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_down_q, key_down_d;

    logic          sample;
    logic          scan_end;
    logic [3:0]    row_low;
    logic [2:0]    col_hits;
    logic [2:0]    hits_tot;
    logic [1:0]    hits_sat;
    logic [3:0]    key_now;
    scan_res_e     scan_res;
    logic          is_cand;
    logic          accept;
    logic          release_done;
    logic [CW-1:0] cnt_nx;

    row_sync u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_in),
        .q     (row_s)
    );

    assign col_drv = idx_to_onehot_low(col_q);

    // Column dwell and column index
    always_comb begin
        dwell_d = dwell_q + 1'b1;
        col_d   = col_q;
        if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            col_d   = col_q + 2'd1;
        end
    end

    // Accumulate the 16-position result; the column 3 sample is folded in
    // combinationally so the result is ready on the scan-end clock itself.
    always_comb begin
        sample   = (dwell_q == DWELL_LAST);
        scan_end = sample && (col_q == 2'd3);
        row_low  = ~row_s;
        col_hits = pop4(row_low);
        hits_tot = {1'b0, acc_n_q} + col_hits;
        hits_sat = (hits_tot >= 3'd2) ? 2'd2 : hits_tot[1:0];
        key_now  = acc_key_q;
        if (acc_n_q == 2'd0 && col_hits == 3'd1) begin
            key_now = {col_q, low_index(row_low)};
        end

        case (hits_sat)
            2'd0:    scan_res = RES_NONE;
            2'd1:    scan_res = RES_SINGLE;
            default: scan_res = RES_MULTI;
        endcase

        acc_n_d   = acc_n_q;
        acc_key_d = acc_key_q;
        if (scan_end) begin
            acc_n_d   = '0;
            acc_key_d = '0;
        end else if (sample) begin
            acc_n_d   = hits_sat;
            acc_key_d = key_now;
        end
    end

    // Press / release state machine, stepped once per full scan
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        c_d          = c_q;
        r_d          = r_q;
        key_code_d   = key_code_q;
        key_valid_d  = 1'b0;
        key_down_d   = key_down_q;
        cnt_nx       = cnt_q;
        accept       = 1'b0;
        release_done = 1'b0;
        is_cand      = (scan_res == RES_SINGLE) && (key_now == cand_q);

        if (scan_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_res == RES_SINGLE) begin
                        cand_d = key_now;
                        cnt_nx = CW'(1);
                        if (cnt_nx == CNT_MAX) begin
                            accept = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = cnt_nx;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (is_cand) begin
                        cnt_nx = cnt_inc(cnt_q);
                        if (cnt_nx == CNT_MAX) begin
                            accept = 1'b1;
                        end else begin
                            cnt_d = cnt_nx;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (!is_cand) begin
                        cnt_nx = CW'(1);
                        if (cnt_nx == CNT_MAX) begin
                            release_done = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                            cnt_d   = cnt_nx;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (is_cand) begin
                        // Contact came back before the release was confirmed.
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_nx = cnt_inc(cnt_q);
                        if (cnt_nx == CNT_MAX) begin
                            release_done = 1'b1;
                        end else begin
                            cnt_d = cnt_nx;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (accept) begin
            state_d     = ST_PRESSED;
            cnt_d       = '0;
            key_valid_d = 1'b1;
            c_d         = idx_to_onehot_low(key_now[3:2]);
            r_d         = idx_to_onehot_low(key_now[1:0]);
            key_code_d  = key_now;
            key_down_d  = 1'b1;
        end

        if (release_done) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            c_d        = NO_KEY;
            r_d        = NO_KEY;
            key_down_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_q     <= '0;
            col_q       <= '0;
            acc_n_q     <= '0;
            acc_key_q   <= '0;
            state_q     <= ST_IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            c_q         <= NO_KEY;
            r_q         <= NO_KEY;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            acc_n_q     <= acc_n_d;
            acc_key_q   <= acc_key_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            r_q         <= r_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign kp.c         = c_q;
    assign kp.r         = r_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3 (T = 16 clocks).
//   A key matrix model drives row_in from col_drv; a scan-level reference
//   model predicts every output each clock. Directed scenarios are followed
//   by randomized key activity.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int T  = 4 * SD;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  col_drv;
    logic [3:0]  row_in;
    logic [15:0] keys = '0;     // bit col*4+row set = key pressed

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    keypad_scanner_if kp_if ();

    keypad_scanner #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CNT (DB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .col_drv (col_drv),
        .row_in  (row_in),
        .kp      (kp_if)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to the driven column.
    always_comb begin
        row_in = 4'hF;
        for (int cc = 0; cc < 4; cc++) begin
            if (!col_drv[cc]) begin
                for (int rr = 0; rr < 4; rr++) begin
                    if (keys[cc*4+rr]) row_in[rr] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] kbit(input int col, input int row);
        logic [15:0] b;
        b = 16'h1;
        return b << (col * 4 + row);
    endfunction

    function automatic logic [3:0] oh_low(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    // ---------------- reference model (scan level) ----------------
    int          m_t = 0;        // clock position within a full scan
    logic [15:0] m_k1 = '0, m_k2 = '0;
    int          m_hits = 0;
    int          m_key = 0;
    bit          m_held = 0;
    int          m_cand = 0;
    int          m_streak = 0;
    int          m_rel = 0;
    logic [3:0]  e_col = 4'hE, e_c = 4'hF, e_r = 4'hF, e_code = 4'h0;
    logic        e_valid = 1'b0, e_down = 1'b0;

    task automatic model_scan(input int hits, input int key);
        bit single;
        single = (hits == 1);
        if (!m_held) begin
            if (single && m_streak > 0 && key == m_cand) m_streak++;
            else if (single && m_streak == 0) begin
                m_cand   = key;
                m_streak = 1;
            end else m_streak = 0;
            if (m_streak == DB) begin
                m_held   = 1;
                m_rel    = 0;
                m_streak = 0;
                e_valid  = 1'b1;
                e_down   = 1'b1;
                e_c      = oh_low(m_cand / 4);
                e_r      = oh_low(m_cand % 4);
                e_code   = 4'(m_cand);
            end
        end else begin
            if (single && key == m_cand) m_rel = 0;
            else m_rel++;
            if (m_rel == DB) begin
                m_held = 0;
                m_rel  = 0;
                e_c    = 4'hF;
                e_r    = 4'hF;
                e_down = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_t = 0; m_k1 = '0; m_k2 = '0; m_hits = 0; m_key = 0;
                m_held = 0; m_cand = 0; m_streak = 0; m_rel = 0;
                e_col = 4'hE; e_c = 4'hF; e_r = 4'hF; e_code = 4'h0;
                e_valid = 1'b0; e_down = 1'b0;
            end else begin
                int k;
                e_valid = 1'b0;
                k = m_t / SD;
                if ((m_t % SD) == SD - 1) begin
                    // rows seen now were captured by the synchronizer two clocks ago
                    for (int rr = 0; rr < 4; rr++) begin
                        if (m_k2[k*4+rr]) begin
                            m_hits++;
                            if (m_hits == 1) m_key = k * 4 + rr;
                        end
                    end
                    if (k == 3) begin
                        model_scan(m_hits, m_key);
                        m_hits = 0;
                    end
                end
                m_k2  = m_k1;
                m_k1  = keys;
                m_t   = (m_t + 1) % T;
                e_col = oh_low(m_t / SD);
            end
        end
    end

    // Per-clock comparison of all outputs against the model
    initial begin
        forever begin
            logic [17:0] got_v, exp_v;
            @(negedge clk);
            if (kp_if.key_valid) pulses++;
            got_v = {col_drv, kp_if.c, kp_if.r, kp_if.key_code, kp_if.key_valid, kp_if.key_down};
            exp_v = {e_col, e_c, e_r, e_code, e_valid, e_down};
            chk("outputs", 32'(got_v), 32'(exp_v));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int max, output bit got, output int n);
        got = 0;
        n   = 0;
        while (!got && n < max) begin
            step();
            n++;
            if (kp_if.key_valid) got = 1;
        end
    endtask

    initial begin
        bit         got;
        int         n, p0, mode, dur, per, a, b;
        logic       down_min;
        logic [3:0] exp_cd;
        logic [15:0] kb;

        // Reset
        repeat (5) step();
        chk("rst_col", col_drv, 4'hE);
        chk("rst_c", kp_if.c, 4'hF);
        chk("rst_r", kp_if.r, 4'hF);
        chk("rst_code", kp_if.key_code, 4'h0);
        chk("rst_valid", kp_if.key_valid, 1'b0);
        chk("rst_down", kp_if.key_down, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 4 * SD; i++) begin
            step();
            exp_cd = oh_low(((i + 1) / SD) % 4);
            chk("scan_col", col_drv, exp_cd);
            chk("scan_valid", kp_if.key_valid, 1'b0);
        end

        // Clean press of (0,2)
        p0 = pulses;
        keys = kbit(0, 2);
        wait_pulse(4 * T, got, n);
        chk("press_in_4T", got, 1'b1);
        repeat (6 * T - n) step();
        chk("press_pulses", pulses - p0, 1);
        chk("press_c", kp_if.c, 4'b1110);
        chk("press_r", kp_if.r, 4'b1011);
        chk("press_code", kp_if.key_code, 4'h2);
        chk("press_down", kp_if.key_down, 1'b1);
        keys = '0;
        repeat (4 * T) step();
        chk("rel_c", kp_if.c, 4'hF);
        chk("rel_r", kp_if.r, 4'hF);
        chk("rel_down", kp_if.key_down, 1'b0);

        // Bounce on (1,0)
        p0 = pulses;
        for (int i = 0; i < 5 * T; i++) begin
            if (i % 10 == 0) keys = keys ^ kbit(1, 0);
            step();
        end
        chk("bounce_no_pulse", pulses - p0, 0);
        keys = kbit(1, 0);
        wait_pulse(6 * T, got, n);
        chk("bounce_accept", got, 1'b1);
        chk("bounce_code", kp_if.key_code, 4'h4);
        repeat (2 * T) step();
        chk("bounce_pulses", pulses - p0, 1);
        keys = '0;
        repeat (5 * T) step();

        // Two keys at once
        p0 = pulses;
        keys = kbit(0, 0) | kbit(2, 3);
        repeat (8 * T) step();
        chk("multi_pulses", pulses - p0, 0);
        chk("multi_c", kp_if.c, 4'hF);
        chk("multi_r", kp_if.r, 4'hF);
        keys = '0;
        repeat (2 * T) step();

        // One-scan dropout while (3,3) is held
        keys = kbit(3, 3);
        wait_pulse(6 * T, got, n);
        chk("glitch_accept", got, 1'b1);
        repeat (2 * T) step();
        p0 = pulses;
        down_min = 1'b1;
        keys = '0;
        for (int i = 0; i < T; i++) begin
            step();
            down_min = down_min & kp_if.key_down;
        end
        keys = kbit(3, 3);
        for (int i = 0; i < 4 * T; i++) begin
            step();
            down_min = down_min & kp_if.key_down;
        end
        chk("glitch_down_held", down_min, 1'b1);
        chk("glitch_pulses", pulses - p0, 0);
        keys = '0;
        repeat (5 * T) step();

        // Reset while (1,2) is held
        keys = kbit(1, 2);
        wait_pulse(6 * T, got, n);
        chk("mid_accept", got, 1'b1);
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_c", kp_if.c, 4'hF);
        chk("mid_rst_r", kp_if.r, 4'hF);
        chk("mid_rst_down", kp_if.key_down, 1'b0);
        chk("mid_rst_valid", kp_if.key_valid, 1'b0);
        chk("mid_rst_code", kp_if.key_code, 4'h0);
        step();
        reset = 1'b1;
        wait_pulse(6 * T, got, n);
        chk("rearm_accept", got, 1'b1);
        chk("rearm_latency", (n >= 3 * T && n <= 4 * T), 1'b1);
        chk("rearm_code", kp_if.key_code, 4'h6);
        keys = '0;
        repeat (5 * T) step();

        // Randomized key activity
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 5);
            dur  = $urandom_range(T, 8 * T);
            case (mode)
                0: keys = '0;
                1, 2: keys = kbit($urandom_range(0, 3), $urandom_range(0, 3));
                3: begin
                    a = $urandom_range(0, 15);
                    b = (a + $urandom_range(1, 15)) % 16;
                    keys = kbit(a / 4, a % 4) | kbit(b / 4, b % 4);
                end
                4: begin
                    kb  = kbit($urandom_range(0, 3), $urandom_range(0, 3));
                    per = $urandom_range(2, 12);
                    keys = '0;
                    for (int i = 0; i < dur; i++) begin
                        if (i % per == 0) keys = keys ^ kb;
                        step();
                    end
                    keys = kb;
                end
                default: begin
                    reset = 1'b0;
                    step();
                    reset = 1'b1;
                end
            endcase
            repeat (dur) step();
        end
        keys = '0;
        repeat (6 * T) step();
        chk("final_c", kp_if.c, 4'hF);
        chk("final_down", kp_if.key_down, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
